// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Brief    : Bundle between the Y86-64 fetch stage and its neighbours:
//             instruction-memory load port, PC-update handshake and the
//             decoded instruction fields.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_if;
  // memory load port
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  // PC-update handshake
  logic        pc_en;
  logic [63:0] pc_next;
  // fetched instruction
  logic [63:0] pc;
  logic        fetch_valid;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;

  // fetch stage side: produces the instruction fields
  modport master (
    input  imem_we, imem_addr, imem_wdata, pc_en, pc_next,
    output pc, fetch_valid, icode, ifun, rA, rB, valC, valP, stat
  );

  // consumer side: loads memory and acknowledges instructions
  modport slave (
    output imem_we, imem_addr, imem_wdata, pc_en, pc_next,
    input  pc, fetch_valid, icode, ifun, rA, rB, valC, valP, stat
  );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module   : fetch
//  Brief    : Y86-64 SEQ fetch stage. Holds the PC and a byte-wide
//             instruction memory, splits one instruction into
//             icode/ifun/rA/rB/valC/valP and classifies its status.
//  Revision : 1.0  initial release
// ============================================================================
module fetch #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MEM_TOP   = 64'(MEM_BYTES);
  localparam logic [64:0] MEM_TOP65 = 65'(MEM_BYTES);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  logic [7:0]  mem [MEM_BYTES];

  state_t      state;
  logic [63:0] pc_q;
  logic        valid_q;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [63:0] valc_q, valp_q;
  logic [2:0]  stat_q;

  logic [63:0] rd_addr [10];
  logic [7:0]  ib      [10];

  logic [3:0]  len;
  logic        has_reg, c_at2, c_at1, ifun_ok;
  logic [64:0] end_addr;
  logic        adr, ins, pc_in;
  logic [63:0] c_lo, c_hi;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
  logic [63:0] d_valc, d_valp;
  logic [2:0]  d_stat;

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = valid_q;
  assign bus.icode       = icode_q;
  assign bus.ifun        = ifun_q;
  assign bus.rA          = ra_q;
  assign bus.rB          = rb_q;
  assign bus.valC        = valc_q;
  assign bus.valP        = valp_q;
  assign bus.stat        = stat_q;

  // Byte write port; out-of-range writes are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (bus.imem_addr < MEM_TOP))
      mem[bus.imem_addr[AW-1:0]] <= bus.imem_wdata;
  end

  // Read the ten bytes at pc..pc+9; bytes beyond the memory read as zero.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      rd_addr[i] = pc_q + 64'(i);
      ib[i]      = (rd_addr[i] < MEM_TOP) ? mem[rd_addr[i][AW-1:0]] : 8'h00;
    end
  end

  // Instruction length, field presence and function-code legality per icode.
  always_comb begin
    len     = 4'd1;
    has_reg = 1'b0;
    c_at2   = 1'b0;
    c_at1   = 1'b0;
    ifun_ok = 1'b0;
    case (ib[0][7:4])
      4'h0, 4'h1, 4'h9: begin
        len = 4'd1; ifun_ok = (ib[0][3:0] == 4'h0);
      end
      4'h2: begin
        len = 4'd2; has_reg = 1'b1; ifun_ok = (ib[0][3:0] <= 4'h6);
      end
      4'h6: begin
        len = 4'd2; has_reg = 1'b1; ifun_ok = (ib[0][3:0] <= 4'h3);
      end
      4'hA, 4'hB: begin
        len = 4'd2; has_reg = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0);
      end
      4'h3, 4'h4, 4'h5: begin
        len = 4'd10; has_reg = 1'b1; c_at2 = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0);
      end
      4'h7: begin
        len = 4'd9; c_at1 = 1'b1; ifun_ok = (ib[0][3:0] <= 4'h6);
      end
      4'h8: begin
        len = 4'd9; c_at1 = 1'b1; ifun_ok = (ib[0][3:0] == 4'h0);
      end
      default: begin
        len = 4'd1; ifun_ok = 1'b0;
      end
    endcase
  end

  // Status classification (ADR > INS > HLT > AOK) and output field selection.
  always_comb begin
    // 65-bit end address catches both overrun and wrap past 2^64
    end_addr = {1'b0, pc_q} + {61'd0, len} - 65'd1;
    adr      = (end_addr >= MEM_TOP65);
    ins      = !ifun_ok;
    pc_in    = (pc_q < MEM_TOP);
    c_lo     = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
    c_hi     = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};

    d_icode  = pc_in ? ib[0][7:4] : 4'h0;
    d_ifun   = pc_in ? ib[0][3:0] : 4'h0;
    d_ra     = 4'hF;
    d_rb     = 4'hF;
    d_valc   = 64'd0;
    d_valp   = pc_q;
    d_stat   = STAT_AOK;

    if (adr) begin
      d_stat = STAT_ADR;
    end else if (ins) begin
      d_stat = STAT_INS;
    end else begin
      d_stat = (ib[0][7:4] == 4'h0) ? STAT_HLT : STAT_AOK;
      d_valp = pc_q + {60'd0, len};
      if (has_reg) begin
        d_ra = ib[1][7:4];
        d_rb = ib[1][3:0];
      end
      if (c_at2)
        d_valc = c_hi;
      else if (c_at1)
        d_valc = c_lo;
    end
  end

  // Control FSM: fetch once, wait for the ack, or stick in HALT on a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      icode_q <= 4'h1;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= STAT_AOK;
    end else begin
      case (state)
        S_FETCH: begin
          icode_q <= d_icode;
          ifun_q  <= d_ifun;
          ra_q    <= d_ra;
          rb_q    <= d_rb;
          valc_q  <= d_valc;
          valp_q  <= d_valp;
          stat_q  <= d_stat;
          valid_q <= 1'b1;
          state   <= (d_stat == STAT_AOK) ? S_WAIT : S_HALT;
        end
        S_WAIT: begin
          if (bus.pc_en) begin
            pc_q    <= bus.pc_next;
            valid_q <= 1'b0;
            state   <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
